// File: rtl/uart_periph_if.sv
// CPU data-bus bundle seen by the UART peripheral: strobes, address, write data
// and the same-cycle read data returned by the peripheral.
`timescale 1ns/1ps
interface uart_periph_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, wr, addr, wdata, input rdata);
  modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART (TXD/RXD/CON registers) with level interrupt.
// Optional even parity in both directions when UART_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_periph #(
  parameter int         CLK_DIV = 5208,
  parameter logic [7:0] BASE    = 8'h18
) (
  input  logic          clk,
  input  logic          reset,
  uart_periph_if.slave  bus,
  output logic          irq,
  input  logic          uart_rx,
  output logic          uart_tx
);
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int             CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [7:0]     A_TXD     = BASE;
  localparam logic [7:0]     A_RXD     = BASE + 8'd4;
  localparam logic [7:0]     A_CON     = BASE + 8'd8;

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;

  tx_state_t     r_tx_state, w_tx_state_nxt;
  rx_state_t     r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt, r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]    r_tx_bit, w_tx_bit_nxt, r_rx_bit, w_rx_bit_nxt;
  logic [7:0]    r_tx_data, r_rx_shift, w_rx_shift_nxt, r_rx_data;
  logic          r_tx, w_tx_line, w_tx_end;
  logic          r_tx_ie, r_rx_ie, r_tx_done, r_rx_valid, r_overrun, r_parity_err;
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic          r_rx_perr, w_rx_perr_nxt, w_rx_load, w_rx_perr_evt;
  logic          w_sel_txd, w_sel_rxd, w_sel_con, w_wr_txd, w_wr_con, w_rd_rxd, w_tx_busy;
  logic          w_unused;

  assign w_sel_txd = bus.addr[30] && (bus.addr[7:0] == A_TXD);
  assign w_sel_rxd = bus.addr[30] && (bus.addr[7:0] == A_RXD);
  assign w_sel_con = bus.addr[30] && (bus.addr[7:0] == A_CON);
  assign w_tx_busy = (r_tx_state != T_IDLE);
  assign w_wr_txd  = bus.wr && w_sel_txd && !w_tx_busy;
  assign w_wr_con  = bus.wr && w_sel_con;
  assign w_rd_rxd  = bus.rd && w_sel_rxd;
  assign w_unused  = &{1'b0, bus.addr[31], bus.addr[29:8], bus.wdata[31:8], bus.wdata[4:3]};

  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      if (w_sel_txd)      bus.rdata = {24'b0, r_tx_data};
      else if (w_sel_rxd) bus.rdata = {24'b0, r_rx_data};
      else if (w_sel_con) bus.rdata = {25'b0, r_parity_err, r_overrun, w_tx_busy,
                                       r_rx_valid, r_tx_done, r_rx_ie, r_tx_ie};
    end
  end

  assign irq     = (r_tx_ie & r_tx_done) | (r_rx_ie & r_rx_valid);
  assign uart_tx = r_tx;

  // TX next-state; the line level is derived from the next state so uart_tx is registered
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + CW'(1);
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_end       = 1'b0;
    w_tx_line      = 1'b1;
    case (r_tx_state)
      T_IDLE: begin
        w_tx_cnt_nxt = '0;
        if (w_wr_txd) w_tx_state_nxt = T_START;
      end
      T_START: if (r_tx_cnt == DIV_LAST) begin
        w_tx_cnt_nxt   = '0;
        w_tx_bit_nxt   = '0;
        w_tx_state_nxt = T_DATA;
      end
      T_DATA: if (r_tx_cnt == DIV_LAST) begin
        w_tx_cnt_nxt = '0;
        if (r_tx_bit == 3'd7) begin
          if (PAR_EN) w_tx_state_nxt = T_PARITY;
          else        w_tx_state_nxt = T_STOP;
        end else begin
          w_tx_bit_nxt = r_tx_bit + 3'd1;
        end
      end
      T_PARITY: if (r_tx_cnt == DIV_LAST) begin
        w_tx_cnt_nxt   = '0;
        w_tx_state_nxt = T_STOP;
      end
      T_STOP: if (r_tx_cnt == DIV_LAST) begin
        w_tx_cnt_nxt   = '0;
        w_tx_state_nxt = T_IDLE;
        w_tx_end       = 1'b1;
      end
      default: w_tx_state_nxt = T_IDLE;
    endcase
    case (w_tx_state_nxt)
      T_START:  w_tx_line = 1'b0;
      T_DATA:   w_tx_line = r_tx_data[w_tx_bit_nxt];
      T_PARITY: w_tx_line = ^r_tx_data;
      default:  w_tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= T_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx       <= w_tx_line;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_txd) r_tx_data <= bus.wdata[7:0];
  end

  // RX: falling edge starts a frame, mid-bit samples every CLK_DIV cycles
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + CW'(1);
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_perr_nxt  = r_rx_perr;
    w_rx_load      = 1'b0;
    w_rx_perr_evt  = 1'b0;
    case (r_rx_state)
      R_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_prev && !r_rx_s2) w_rx_state_nxt = R_START;
      end
      R_START: if (r_rx_cnt == HALF_LAST) begin
        w_rx_cnt_nxt = '0;
        w_rx_bit_nxt = '0;
        if (r_rx_s2) w_rx_state_nxt = R_IDLE;
        else         w_rx_state_nxt = R_DATA;
      end
      R_DATA: if (r_rx_cnt == DIV_LAST) begin
        w_rx_cnt_nxt   = '0;
        w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
        if (r_rx_bit == 3'd7) begin
          if (PAR_EN) w_rx_state_nxt = R_PARITY;
          else        w_rx_state_nxt = R_STOP;
        end else begin
          w_rx_bit_nxt = r_rx_bit + 3'd1;
        end
      end
      R_PARITY: if (r_rx_cnt == DIV_LAST) begin
        w_rx_cnt_nxt   = '0;
        w_rx_perr_nxt  = r_rx_s2 ^ (^r_rx_shift);
        w_rx_state_nxt = R_STOP;
      end
      R_STOP: if (r_rx_cnt == DIV_LAST) begin
        w_rx_cnt_nxt   = '0;
        w_rx_state_nxt = R_IDLE;
        if (r_rx_s2) begin
          if (PAR_EN && r_rx_perr) w_rx_perr_evt = 1'b1;
          else                     w_rx_load     = 1'b1;
        end
      end
      default: w_rx_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= R_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_perr  <= 1'b0;
    end else begin
      r_rx_s1    <= uart_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_perr  <= (r_rx_state == R_IDLE) ? 1'b0 : w_rx_perr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_rx_shift <= w_rx_shift_nxt;
  end

  // Status/control; a load coinciding with an RXD read is not an overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_ie      <= 1'b0;
      r_rx_ie      <= 1'b0;
      r_tx_done    <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
      r_rx_data    <= '0;
    end else begin
      if (w_wr_con) begin
        r_tx_ie <= bus.wdata[0];
        r_rx_ie <= bus.wdata[1];
      end
      if (w_tx_end)                       r_tx_done <= 1'b1;
      else if (w_wr_con && bus.wdata[2])  r_tx_done <= 1'b0;
      if (w_rx_load) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_rd_rxd) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_load && r_rx_valid && !w_rd_rxd) r_overrun <= 1'b1;
      else if (w_wr_con && bus.wdata[5])        r_overrun <= 1'b0;
      if (w_rx_perr_evt)                        r_parity_err <= 1'b1;
      else if (w_wr_con && bus.wdata[6])        r_parity_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_periph.sv
// Directed-plus-random bench for uart_periph at CLK_DIV=4; expected frames and
// register values come from the frame rules (start/LSB-first data/stop) and flag rules.
`timescale 1ns/1ps
module tb_uart_periph;
  localparam int          DIV   = 4;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic clk = 1'b0;
  logic reset, irq, uart_rx, uart_tx;
  int   checks = 0;
  int   errors = 0;

  uart_periph_if bus();

  uart_periph #(.CLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .bus(bus), .irq(irq), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.rd = 1'b1; bus.addr = a; #1;
    d = bus.rdata;
    @(posedge clk); #1;
    bus.rd = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.wr = 1'b0;
  endtask

  // Transmit b and compare every cycle of the serial waveform against the frame.
  task automatic tx_check(input logic [7:0] b, input string tag);
    logic [9:0]  f;
    logic [39:0] got, exp;
    f = {1'b1, b, 1'b0};
    bus_write(A_TXD, {24'b0, b});
    for (int i = 0; i < 40; i++) begin
      got[i] = uart_tx;
      exp[i] = f[i / DIV];
      cyc();
    end
    check(tag, got, exp);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0]  f;
    logic [7:0]  b;
    int          lows;

    reset = 1'b1; uart_rx = 1'b1;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("reset_tx", uart_tx, 1'b1);
    check("reset_irq", irq, 1'b0);
    check("rdata_idle", bus.rdata, 32'h0);
    bus_read(A_CON, d);          check("reset_con", d, 32'h0);
    bus_read(32'h4000_0000, d);  check("nomatch_rd", d, 32'h0);
    bus_read(32'h0000_0020, d);  check("no_bit30_rd", d, 32'h0);

    bus_write(A_CON, 32'h1);
    check("irq_txie_idle", irq, 1'b0);

    f = {1'b1, 8'hA5, 1'b0};
    bus_write(A_TXD, 32'h0000_00A5);
    for (int i = 0; i < 40; i++) begin
      if (i == 12) begin
        bus.rd = 1'b0; bus.wr = 1'b1; bus.addr = A_TXD; bus.wdata = 32'h3C;
      end else begin
        bus.wr = 1'b0; bus.rd = 1'b1; bus.addr = A_CON;
      end
      #1;
      check($sformatf("tx_a5_bit%0d", i), uart_tx, f[i / DIV]);
      if (i != 12) begin
        check($sformatf("tx_a5_con%0d", i), bus.rdata, 32'h11);
        check($sformatf("tx_a5_irq%0d", i), irq, 1'b0);
      end
      cyc();
    end
    bus.rd = 1'b0; bus.wr = 1'b0;
    bus_read(A_CON, d);  check("tx_done_con", d, 32'h5);
    check("tx_done_irq", irq, 1'b1);
    lows = 0;
    for (int i = 0; i < 48; i++) begin
      if (uart_tx !== 1'b1) lows++;
      cyc();
    end
    check("busy_write_dropped", lows, 0);
    bus_read(A_TXD, d);  check("txd_readback", d, 32'hA5);
    bus_write(A_CON, 32'h4);
    bus_read(A_CON, d);  check("tx_done_clear", d, 32'h0);
    check("irq_after_clear", irq, 1'b0);

    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      tx_check(b, $sformatf("tx_rand%0d_%02h", k, b));
      bus_read(A_TXD, d);  check($sformatf("txd_rand%0d", k), d, {24'b0, b});
      bus_read(A_CON, d);  check($sformatf("tx_rand_con%0d", k), d, 32'h4);
      bus_write(A_CON, 32'h4);
    end

    bus_write(A_CON, 32'h2);
    rx_send(8'h5A, 1'b1);
    bus_read(A_CON, d);  check("rx_valid_con", d, 32'h0A);
    check("rx_irq_set", irq, 1'b1);
    bus_read(A_RXD, d);  check("rxd_5a", d, 32'h5A);
    check("rx_irq_clear", irq, 1'b0);
    bus_read(A_CON, d);  check("rx_valid_clear", d, 32'h02);

    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      rx_send(b, 1'b1);
      bus_read(A_CON, d);  check($sformatf("rx_rand_con%0d", k), d, 32'h0A);
      bus_read(A_RXD, d);  check($sformatf("rx_rand%0d_%02h", k, b), d, {24'b0, b});
    end

    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    bus_read(A_CON, d);  check("overrun_con", d, 32'h2A);
    bus_read(A_RXD, d);  check("overrun_rxd", d, 32'h22);
    bus_write(A_CON, 32'h22);
    bus_read(A_CON, d);  check("overrun_clear", d, 32'h02);

    uart_rx = 1'b0; cyc();
    uart_rx = 1'b1;
    repeat (60) cyc();
    bus_read(A_CON, d);  check("glitch_no_byte", d, 32'h02);
    check("glitch_irq", irq, 1'b0);

    b = 8'($urandom);
    rx_send(b, 1'b0);
    repeat (10) cyc();
    bus_read(A_CON, d);  check("framing_err_con", d, 32'h02);
    bus_read(A_RXD, d);  check("framing_keeps_rxd", d, 32'h22);

    b = 8'($urandom);
    rx_send(b, 1'b1);
    bus_read(A_RXD, d);  check("rx_after_ferr", d, {24'b0, b});

    bus_write(A_CON, 32'h0);
    bus_write(A_TXD, 32'h0);
    repeat (10) cyc();
    check("mid_tx_low", uart_tx, 1'b0);
    reset = 1'b1;
    cyc();
    check("reset_mid_tx", uart_tx, 1'b1);
    reset = 1'b0;
    bus_read(A_CON, d);  check("con_after_reset", d, 32'h0);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      if (uart_tx !== 1'b1) lows++;
      cyc();
    end
    check("tx_idle_after_reset", lows, 0);
    bus_read(A_RXD, d);  check("rxd_after_reset", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
